perceptron_trainer: RTL and testbench
=====================================

PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

Interface
REQ-001 SHALL have parameter H, default 10, meaning history length and weights per row excluding bias.
REQ-002 SHALL have parameter W_WIDTH, default 8, meaning signed weight width.
REQ-003 SHALL have parameter THETA, default 33, meaning training threshold, floor(1.93*H+14).
REQ-004 SHALL have port clk  in  1  single clock; all flops on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port train_valid  in  1  EX stage presents a resolved conditional branch.
REQ-007 SHALL have port train_ready  out  1  trainer accepts a branch this cycle.
REQ-008 SHALL have port train_idx  in  10  row index used at prediction time (PC xor GHR snapshot).
REQ-009 SHALL have port train_ghr  in  H  GHR snapshot used at prediction time.
REQ-010 SHALL have port train_y  in  W_WIDTH+4  signed perceptron sum computed at prediction.
REQ-011 SHALL have port train_taken  in  1  actual branch outcome.
REQ-012 SHALL have port w_rd_idx  out  10  table row read address.
REQ-013 SHALL have port w_rd_sel  out  4  weight select within row (0 = bias, 1..H = history weights).
REQ-014 SHALL have port w_rd_data  in  W_WIDTH  signed weight, combinational read of (w_rd_idx, w_rd_sel).
REQ-015 SHALL have port w_wr_en  out  1  table write strobe.
REQ-016 SHALL have port w_wr_idx  out  10  table row write address.
REQ-017 SHALL have port w_wr_sel  out  4  weight select for the write.
REQ-018 SHALL have port w_wr_data  out  W_WIDTH  updated signed weight.
REQ-019 SHALL have port ghr  out  H  committed global history register.
REQ-020 SHALL have port train_cnt  out  16  number of rows trained since reset.

Function
REQ-021 SHALL implement the FSM states IDLE and UPDATE; train_ready = 1 only in IDLE.
REQ-022 SHALL accept a branch on the rising edge where train_valid && train_ready; the input fields are captured into internal registers on that edge.
REQ-023 SHALL shift ghr on every accept: ghr <= {ghr[H-2:0], train_taken}, whether or not training occurs.
REQ-024 SHALL define pred = ~train_y[MSB], i.e. taken when y >= 0; mag = |train_y|.
REQ-025 SHALL define need_train = (pred != train_taken) || (mag <= THETA).
REQ-026 SHALL transition IDLE -> UPDATE on accept when need_train = 1, with weight counter k = 0; otherwise it SHALL stay in IDLE.
REQ-027 SHALL, in UPDATE, drive w_rd_idx = captured idx and w_rd_sel = k, and assert w_wr_en combinationally with w_wr_idx = idx, w_wr_sel = k, w_wr_data = sat(w_rd_data + t*x_k).
REQ-028 SHALL use t = +1 if taken, else -1; x_0 = +1; x_k = +1 if captured ghr[k-1] = 1, else -1, for k = 1..H.
REQ-029 SHALL saturate sat() symmetrically to [-(2^(W_WIDTH-1)-1), +(2^(W_WIDTH-1)-1)], i.e. -127..127 at the default width; the value -128 is never written.
REQ-030 SHALL increment k each UPDATE cycle; when k = H, it SHALL return to IDLE and increment train_cnt, which wraps at 16 bits.
REQ-031 SHALL meet this latency: accept at edge T, writes during cycles T+1..T+H+1 (H+1 writes), train_ready high again from cycle T+H+2.
REQ-032 SHALL ignore train_valid while in UPDATE; no capture and no ghr shift occur, and upstream holds the request.
REQ-033 SHALL take the boundary case y = THETA as trained and y = THETA+1 with a correct prediction as not trained; y = -THETA-1 with a correct prediction is also not trained.
REQ-034 SHALL keep w_wr_en = 0 in IDLE.

Reset
REQ-035 SHALL, while rst = 0, force state = IDLE, k = 0, ghr = 0, train_cnt = 0, captured registers = 0, w_wr_en = 0, train_ready = 1.
REQ-036 SHALL, on reset asserted mid-UPDATE, abort immediately with no further writes; already-written weights of that row stay as written.

Verification
REQ-037 SHALL cover: w=0 rows, accept idx=5, ghr=10'b0000000001, taken=1, y=0 -> writes sel0=+1, sel1=+1, sel2..10=-1; ready low 11 cycles; train_cnt=1.
REQ-038 SHALL cover: correct prediction, y=+40, taken=1 -> no writes, ready stays 1, ghr shifts in 1, train_cnt unchanged.
REQ-039 SHALL cover: w_rd_data=+127, t*x=+1 -> w_wr_data=+127; w_rd_data=-127, t*x=-1 -> w_wr_data=-127.
REQ-040 SHALL cover: y=+33 and taken=1 -> trains; y=+34 and taken=1 -> no train; y=+34 and taken=0 -> trains.
REQ-041 SHALL cover: train_valid held during UPDATE -> no second accept until cycle T+H+2, then accepted once, ghr shifted exactly twice total.
REQ-042 SHALL cover: rst dropped at UPDATE k=4 -> w_wr_en=0 same cycle, ghr=0, train_cnt=0, ready=1 after release.

Source files
------------

// File: rtl/perceptron_trainer.sv
// Perceptron branch-predictor trainer.
// Takes each resolved conditional branch from EX and shifts its outcome into
// the committed global history. When the prediction was wrong, or the
// perceptron output magnitude was at or below THETA, it walks the bias and
// history weights of the row used at prediction time. It reads each weight,
// adds or subtracts one, saturates the result and writes it back, one weight
// per cycle.
module perceptron_trainer #(
  parameter int H       = 10,
  parameter int W_WIDTH = 8,
  parameter int THETA   = 33
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      train_valid,
  output logic                      train_ready,
  input  logic [9:0]                train_idx,
  input  logic [H-1:0]              train_ghr,
  input  logic signed [W_WIDTH+3:0] train_y,
  input  logic                      train_taken,
  output logic [9:0]                w_rd_idx,
  output logic [3:0]                w_rd_sel,
  input  logic signed [W_WIDTH-1:0] w_rd_data,
  output logic                      w_wr_en,
  output logic [9:0]                w_wr_idx,
  output logic [3:0]                w_wr_sel,
  output logic signed [W_WIDTH-1:0] w_wr_data,
  output logic [H-1:0]              ghr,
  output logic [15:0]               train_cnt
);

  localparam int YW = W_WIDTH + 4;

  // The magnitude is one bit wider than y so that |most-negative| fits.
  localparam logic [YW:0] THETA_V = (YW+1)'(THETA);
  localparam logic [3:0]  K_LAST  = 4'(H);

  // Symmetric saturation bounds. The most negative code is never produced.
  localparam logic signed [W_WIDTH:0] SAT_MAX  = (W_WIDTH+1)'((2 ** (W_WIDTH - 1)) - 1);
  localparam logic signed [W_WIDTH:0] SAT_MIN  = -SAT_MAX;
  localparam logic signed [W_WIDTH:0] STEP_POS = (W_WIDTH+1)'(1);
  localparam logic signed [W_WIDTH:0] STEP_NEG = -STEP_POS;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  state_t       state_reg;
  logic [3:0]   k_reg;
  logic [9:0]   idx_reg;
  logic [H-1:0] ghr_cap_reg;
  logic         taken_reg;
  logic [H-1:0] ghr_reg;
  logic [15:0]  cnt_reg;

  logic signed [YW:0]      y_ext;
  logic [YW:0]             mag;
  logic                    pred;
  logic                    need_train;
  logic [H:0]              x_vec;
  logic                    x_pos;
  logic signed [W_WIDTH:0] step;
  logic signed [W_WIDTH:0] sum_ext;

  // Decide whether the incoming branch needs its row trained.
  always_comb begin
    y_ext      = {train_y[YW-1], train_y};
    mag        = y_ext[YW] ? $unsigned(-y_ext) : $unsigned(y_ext);
    pred       = ~train_y[YW-1];
    need_train = (pred != train_taken) || (mag <= THETA_V);
  end

  // Produce the weight update for index k.
  // x_vec[0] is the constant bias input and x_vec[k] is history bit k-1.
  // The weight steps up when the input agrees with the outcome, and steps
  // down otherwise.
  always_comb begin
    x_vec   = {ghr_cap_reg, 1'b1};
    x_pos   = x_vec[k_reg];
    step    = (x_pos == taken_reg) ? STEP_POS : STEP_NEG;
    sum_ext = $signed({w_rd_data[W_WIDTH-1], w_rd_data}) + step;
    if (sum_ext > SAT_MAX) begin
      w_wr_data = SAT_MAX[W_WIDTH-1:0];
    end else if (sum_ext < SAT_MIN) begin
      w_wr_data = SAT_MIN[W_WIDTH-1:0];
    end else begin
      w_wr_data = sum_ext[W_WIDTH-1:0];
    end
  end

  // The table port and the status outputs come straight from the state registers.
  always_comb begin
    train_ready = (state_reg == IDLE);
    w_wr_en     = (state_reg == UPDATE);
    w_rd_idx    = idx_reg;
    w_rd_sel    = k_reg;
    w_wr_idx    = idx_reg;
    w_wr_sel    = k_reg;
    ghr         = ghr_reg;
    train_cnt   = cnt_reg;
  end

  // Control FSM.
  // IDLE accepts a branch and shifts its outcome into the history.
  // UPDATE steps through weights 0..H and then returns to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      k_reg       <= '0;
      idx_reg     <= '0;
      ghr_cap_reg <= '0;
      taken_reg   <= 1'b0;
      ghr_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (train_valid) begin
            idx_reg     <= train_idx;
            ghr_cap_reg <= train_ghr;
            taken_reg   <= train_taken;
            ghr_reg     <= {ghr_reg[H-2:0], train_taken};
            k_reg       <= '0;
            if (need_train) begin
              state_reg <= UPDATE;
            end
          end
        end
        UPDATE: begin
          if (k_reg == K_LAST) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            cnt_reg   <= cnt_reg + 16'd1;
          end else begin
            k_reg <= k_reg + 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Testbench for perceptron_trainer.
// The bench holds its own model of the weight table.
// Each accepted training request pushes its expected writes onto a queue.
// A negedge monitor pops the queue as the writes appear.
module tb_perceptron_trainer;

  localparam int H = 10;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                train_valid = 1'b0;
  logic                train_ready;
  logic [9:0]          train_idx = '0;
  logic [H-1:0]        train_ghr = '0;
  logic signed [W+3:0] train_y = '0;
  logic                train_taken = 1'b0;
  logic [9:0]          w_rd_idx;
  logic [3:0]          w_rd_sel;
  logic signed [W-1:0] w_rd_data;
  logic                w_wr_en;
  logic [9:0]          w_wr_idx;
  logic [3:0]          w_wr_sel;
  logic signed [W-1:0] w_wr_data;
  logic [H-1:0]        ghr;
  logic [15:0]         train_cnt;

  perceptron_trainer #(.H(H), .W_WIDTH(W), .THETA(33)) dut (
    .clk(clk), .rst(rst),
    .train_valid(train_valid), .train_ready(train_ready),
    .train_idx(train_idx), .train_ghr(train_ghr),
    .train_y(train_y), .train_taken(train_taken),
    .w_rd_idx(w_rd_idx), .w_rd_sel(w_rd_sel), .w_rd_data(w_rd_data),
    .w_wr_en(w_wr_en), .w_wr_idx(w_wr_idx), .w_wr_sel(w_wr_sel),
    .w_wr_data(w_wr_data), .ghr(ghr), .train_cnt(train_cnt)
  );

  always #5 clk = ~clk;

  // Weight table model.
  // Reset clears every row and preloads rows 20 and 21 for the saturation cases.
  logic signed [W-1:0] mem [1024][16];
  assign w_rd_data = mem[w_rd_idx][w_rd_sel];

  always @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < 1024; r++)
        for (int s = 0; s < 16; s++)
          mem[r][s] <= (r == 20) ? 8'sd127 : ((r == 21) ? -8'sd127 : 8'sd0);
    end else if (w_wr_en) begin
      mem[w_wr_idx][w_wr_sel] <= w_wr_data;
    end
  end

  typedef struct {
    logic [9:0]          idx;
    logic [3:0]          sel;
    logic signed [W-1:0] data;
  } wr_t;

  typedef struct {
    logic [9:0]   idx;
    logic [H-1:0] g;
    int           y;
    bit           taken;
    bit           exp_train;
  } vec_t;

  wr_t          sb_q[$];
  vec_t         vecs[12];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [H-1:0] ghr_m    = '0;
  logic [15:0]  cnt_m    = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Push the H+1 writes that a training pass on this row should produce.
  task automatic push_expected(input logic [9:0] idx, input logic [H-1:0] g, input bit taken);
    int  t;
    int  x;
    int  s;
    wr_t e;
    t = taken ? 1 : -1;
    for (int k = 0; k <= H; k++) begin
      x = (k == 0) ? 1 : (g[k-1] ? 1 : -1);
      s = int'(mem[idx][k]) + t * x;
      if (s > 127)  s = 127;
      if (s < -127) s = -127;
      e.idx  = idx;
      e.sel  = 4'(k);
      e.data = 8'(s);
      sb_q.push_back(e);
    end
  endtask

  // Drive a single-cycle request and follow it until the trainer is idle again.
  task automatic run_tx(input vec_t v);
    int low;
    int y;
    y = v.y;
    @(posedge clk); #1;
    train_valid = 1'b1;
    train_idx   = v.idx;
    train_ghr   = v.g;
    train_y     = y[11:0];
    train_taken = v.taken;
    if (v.exp_train) begin
      push_expected(v.idx, v.g, v.taken);
      cnt_m = cnt_m + 16'd1;
    end
    ghr_m = {ghr_m[H-2:0], v.taken};
    @(posedge clk); #1;
    train_valid = 1'b0;
    low = 0;
    while (!train_ready && low < 30) begin
      low++;
      @(posedge clk); #1;
    end
    $display("tx idx=%0d y=%0d taken=%0d ready_low=%0d ghr=%b cnt=%0d",
             v.idx, v.y, v.taken, low, ghr, train_cnt);
    check("ready_low_cycles", low, v.exp_train ? H + 1 : 0);
    check("ghr", 32'(ghr), 32'(ghr_m));
    check("train_cnt", 32'(train_cnt), 32'(cnt_m));
    check("pending_writes", sb_q.size(), 0);
  endtask

  initial begin
    vec_t v;
    int   low;

    // {idx, ghr snapshot, y, taken, expect training}
    vecs[0]  = '{10'd5,    10'b0000000001,    0, 1'b1, 1'b1};
    vecs[1]  = '{10'd6,    10'b1010101010,   40, 1'b1, 1'b0};
    vecs[2]  = '{10'd7,    10'b1100110011,   33, 1'b1, 1'b1};
    vecs[3]  = '{10'd8,    10'b0000000000,   34, 1'b1, 1'b0};
    vecs[4]  = '{10'd9,    10'b1111100000,   34, 1'b0, 1'b1};
    vecs[5]  = '{10'd10,   10'b0101010101,  -34, 1'b0, 1'b0};
    vecs[6]  = '{10'd11,   10'b0011001100,  -33, 1'b0, 1'b1};
    vecs[7]  = '{10'd20,   10'b1111111111,    0, 1'b1, 1'b1};
    vecs[8]  = '{10'd21,   10'b1111111111,    0, 1'b0, 1'b1};
    vecs[9]  = '{10'd1023, 10'b1000000001, -2048, 1'b1, 1'b1};
    vecs[10] = '{10'd2,    10'b0110000110, 2047, 1'b0, 1'b1};
    vecs[11] = '{10'd3,    10'b0000011111, -100, 1'b0, 1'b0};

    // Write monitor: every strobe must match the head of the scoreboard.
    fork
      forever begin
        @(negedge clk);
        if (rst && w_wr_en) begin
          if (sb_q.size() == 0) begin
            check("unexpected_write", 32'(w_wr_en), 0);
          end else begin
            wr_t e;
            e = sb_q.pop_front();
            $display("wr idx=%0d sel=%0d data=%0d", w_wr_idx, w_wr_sel, w_wr_data);
            check("wr_idx", 32'(w_wr_idx), 32'(e.idx));
            check("wr_sel", 32'(w_wr_sel), 32'(e.sel));
            check("wr_data", 32'(w_wr_data), 32'(e.data));
          end
        end
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(train_ready), 1);
    check("rst_wr_en", 32'(w_wr_en), 0);
    check("rst_ghr", 32'(ghr), 0);
    check("rst_cnt", 32'(train_cnt), 0);
    rst = 1'b1;

    // Table-driven transactions.
    for (int i = 0; i < 12; i++) run_tx(vecs[i]);

    // Request held during UPDATE.
    // The request must be accepted exactly twice: once at the start and once
    // when the trainer is ready again.
    @(posedge clk); #1;
    train_valid = 1'b1;
    train_idx   = 10'd40;
    train_ghr   = 10'b1010101010;
    train_y     = '0;
    train_taken = 1'b1;
    push_expected(10'd40, 10'b1010101010, 1'b1);
    ghr_m = {ghr_m[H-2:0], 1'b1};
    cnt_m = cnt_m + 16'd1;
    @(posedge clk); #1;
    low = 0;
    while (!train_ready && low < 30) begin
      low++;
      if (low == 5) check("hold_ghr_mid", 32'(ghr), 32'(ghr_m));
      @(posedge clk); #1;
    end
    check("hold_first_low", low, H + 1);
    check("hold_ghr_between", 32'(ghr), 32'(ghr_m));
    push_expected(10'd40, 10'b1010101010, 1'b1);
    ghr_m = {ghr_m[H-2:0], 1'b1};
    cnt_m = cnt_m + 16'd1;
    @(posedge clk); #1;
    train_valid = 1'b0;
    low = 0;
    while (!train_ready && low < 30) begin
      low++;
      @(posedge clk); #1;
    end
    $display("hold second pass ready_low=%0d ghr=%b cnt=%0d", low, ghr, train_cnt);
    check("hold_second_low", low, H + 1);
    check("hold_ghr_final", 32'(ghr), 32'(ghr_m));
    check("hold_cnt", 32'(train_cnt), 32'(cnt_m));
    check("hold_pending", sb_q.size(), 0);

    // Reset asserted while the trainer is at k = 4.
    @(posedge clk); #1;
    train_valid = 1'b1;
    train_idx   = 10'd30;
    train_ghr   = 10'b0101010101;
    train_y     = '0;
    train_taken = 1'b1;
    push_expected(10'd30, 10'b0101010101, 1'b1);
    @(posedge clk); #1;
    train_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("mid_wr_en_before", 32'(w_wr_en), 1);
    check("mid_sel_before", 32'(w_wr_sel), 4);
    rst = 1'b0;
    #1;
    $display("reset mid-update wr_en=%0d ghr=%b cnt=%0d ready=%0d", w_wr_en, ghr, train_cnt, train_ready);
    check("mid_rst_wr_en", 32'(w_wr_en), 0);
    check("mid_rst_ghr", 32'(ghr), 0);
    check("mid_rst_cnt", 32'(train_cnt), 0);
    check("mid_rst_left", sb_q.size(), 7);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_wr_en_hold", 32'(w_wr_en), 0);
    rst = 1'b1;
    ghr_m = '0;
    cnt_m = '0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(train_ready), 1);
    check("post_rst_ghr", 32'(ghr), 0);
    check("post_rst_cnt", 32'(train_cnt), 0);

    // Normal training must resume after the reset.
    v = '{10'd12, 10'b0000000001, 0, 1'b0, 1'b1};
    run_tx(v);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
